ecp3_phase_sweep: RTL

ECP3_PHASE_SWEEP -- requirements
Module: ecp3_phase_sweep

---
 rtl/ecp3_csa_pkg.sv | 21 ++
 rtl/phase_window_eval.sv | 70 +++++++
 rtl/ecp3_phase_sweep.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ecp3_csa_pkg.sv
// Shared definitions for the ECP3 clock/strobe alignment phase sweep.
package ecp3_csa_pkg;

   localparam int PHASE_W = 4;
   localparam int NPHASE  = 16;

   localparam logic [1:0] ST_ALIGNED = 2'b00;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      STOP    = 4'd1,
      STEP    = 4'd2,
      RESTART = 4'd3,
      SETTLE  = 4'd4,
      SAMPLE  = 4'd5,
      EVAL    = 4'd6,
      LOCKED  = 4'd7,
      FAILED  = 4'd8
   } state_t;

endpackage

// File: rtl/phase_window_eval.sv
// Circular longest-run-of-ones search over the 16-entry pass map,
// one bit per cycle for two laps so a window wrapping past phase 15 is seen whole.
module phase_window_eval
   import ecp3_csa_pkg::*;
(
   input  logic                 sclk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NPHASE-1:0]    map,
   output logic                 done,
   output logic [4:0]           len,
   output logic [PHASE_W-1:0]   win_start
);

   logic [NPHASE-1:0]  map_q;
   logic [4:0]         pos;
   logic               running;
   logic [4:0]         cur_len;
   logic [PHASE_W-1:0] cur_start;
   logic [4:0]         nxt_len;
   logic [PHASE_W-1:0] nxt_start;

   // Run length saturates at 16 so an all-pass map keeps start 0.
   always_comb begin
      nxt_len   = '0;
      nxt_start = cur_start;
      if (map_q[pos[3:0]]) begin
         nxt_start = (cur_len == 5'd0) ? pos[3:0] : cur_start;
         nxt_len   = (cur_len == 5'd16) ? cur_len : cur_len + 5'd1;
      end
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         map_q     <= '0;
         pos       <= '0;
         running   <= 1'b0;
         cur_len   <= '0;
         cur_start <= '0;
         len       <= '0;
         win_start <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            map_q     <= map;
            pos       <= '0;
            running   <= 1'b1;
            cur_len   <= '0;
            cur_start <= '0;
            len       <= '0;
            win_start <= '0;
         end else if (running) begin
            cur_len   <= nxt_len;
            cur_start <= nxt_start;
            // Strictly longer only: equal runs keep the earlier start.
            if (nxt_len > len) begin
               len       <= nxt_len;
               win_start <= nxt_start;
            end
            pos <= pos + 5'd1;
            if (pos == 5'd31) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ecp3_phase_sweep.sv
// ECLK/SCLK phase sweep: scans all PLL phases, centres on the widest passing window.
// Optional CSA_MARGIN_EN adds margin_code, an offset added to the chosen centre.
module ecp3_phase_sweep
   import ecp3_csa_pkg::*;
#(
   parameter int SETTLE_CYCLES = 128,
   parameter int STOP_CYCLES   = 8,
   parameter int RST_CYCLES    = 4
) (
   input  logic               reset,
   input  logic               sclk,
   input  logic               lock,
   input  logic [1:0]         align_status,
   input  logic               reset_datapath,
`ifdef CSA_MARGIN_EN
   input  logic [3:0]         margin_code,
`endif
   output logic [PHASE_W-1:0] phase,
   output logic               stop_out,
   output logic               reset_datapath_out,
   output logic               good,
   output logic               err,
   output logic               busy
);

   state_t             state;
   logic               lock_m, lock_s;
   logic               rd_m, rd_s, rd_d;
   logic               rd_rise;
   logic [15:0]        cnt;
   logic [PHASE_W-1:0] index;
   logic [NPHASE-1:0]  pass_map;
   logic               apply_mode;
   logic [PHASE_W-1:0] center_q;
   logic               eval_start;
   logic               ev_done;
   logic [4:0]         ev_len;
   logic [PHASE_W-1:0] ev_start;
   logic [4:0]         half;
   logic [PHASE_W-1:0] center;
   logic [PHASE_W-1:0] applied;
   logic               status_pass;

   assign status_pass = (align_status == ST_ALIGNED);
   assign rd_rise     = rd_s & ~rd_d;

   assign half   = (ev_len - 5'd1) >> 1;
   assign center = ev_start + half[3:0];
`ifdef CSA_MARGIN_EN
   assign applied = center + margin_code;
`else
   assign applied = center;
`endif

   assign stop_out           = (state == STOP) || (state == STEP);
   assign reset_datapath_out = (state == RESTART) || ((state == IDLE) && !lock_s);
   assign busy               = !((state == LOCKED) || (state == FAILED));
   assign err                = (state == FAILED);

   phase_window_eval u_eval (
      .sclk      (sclk),
      .reset     (reset),
      .start     (eval_start),
      .map       (pass_map),
      .done      (ev_done),
      .len       (ev_len),
      .win_start (ev_start)
   );

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
         rd_m   <= 1'b0;
         rd_s   <= 1'b0;
         rd_d   <= 1'b0;
      end else begin
         lock_m <= lock;
         lock_s <= lock_m;
         rd_m   <= reset_datapath;
         rd_s   <= rd_m;
         rd_d   <= rd_s;
      end
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         phase      <= '0;
         good       <= 1'b0;
         cnt        <= '0;
         index      <= '0;
         pass_map   <= '0;
         apply_mode <= 1'b0;
         center_q   <= '0;
         eval_start <= 1'b0;
      end else begin
         eval_start <= 1'b0;
         if ((state != IDLE) && !lock_s) begin
            state <= IDLE;
            cnt   <= '0;
            good  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (lock_s) begin
                  pass_map   <= '0;
                  index      <= '0;
                  apply_mode <= 1'b0;
                  cnt        <= '0;
                  state      <= STOP;
               end
               STOP: if (cnt == 16'(STOP_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= STEP;
               end else cnt <= cnt + 16'd1;
               STEP: begin
                  phase <= apply_mode ? center_q : index;
                  state <= RESTART;
               end
               RESTART: if (cnt == 16'(RST_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= SETTLE;
               end else cnt <= cnt + 16'd1;
               SETTLE: if (cnt == 16'(SETTLE_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= SAMPLE;
               end else cnt <= cnt + 16'd1;
               SAMPLE: if (apply_mode) begin
                  state <= LOCKED;
               end else begin
                  pass_map[index] <= status_pass;
                  if (index == 4'd15) begin
                     state      <= EVAL;
                     eval_start <= 1'b1;
                  end else begin
                     index <= index + 4'd1;
                     state <= STOP;
                  end
               end
               EVAL: if (ev_done) begin
                  if (ev_len == 5'd0) begin
                     phase <= '0;
                     state <= FAILED;
                  end else begin
                     center_q   <= applied;
                     apply_mode <= 1'b1;
                     state      <= STOP;
                  end
               end
               LOCKED, FAILED: begin
                  good <= (state == LOCKED) && status_pass;
                  if (rd_rise) begin
                     good       <= 1'b0;
                     pass_map   <= '0;
                     index      <= '0;
                     apply_mode <= 1'b0;
                     cnt        <= '0;
                     state      <= STOP;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
